qdma_h2c_dsc_arbiter: RTL and testbench

- Weighted round-robin arbiter with priority override, sharing the single QDMA H2C descriptor bypass port between the VM agent (ATS requests) and Coyote H2C channels 0/1.
- Replaces the fixed AXIS switch. Adds:
  - per-source weights;
  - a bounded high-priority lane for the VM agent;
  - a pause/drain control;
  - grant statistics.
- Sits between the descriptor packers and the QDMA h2c_byp_in interface.
- The output is a registered single-beat stream.

---
 rtl/qdma_dsc_arb_pkg.sv | 40 ++++
 rtl/dsc_wrr_pick.sv | 39 +++
 rtl/qdma_h2c_dsc_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_qdma_h2c_dsc_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qdma_dsc_arb_pkg.sv
// Shared definitions for the H2C descriptor bypass arbiter: source ids, FSM states, descriptor fields.
// No logic; constants and types only.
// Descriptor field offsets describe the existing packer layout; the arbiter itself treats descriptors as opaque.
package qdma_dsc_arb_pkg;

  // Requester slots on the shared bypass port
  localparam int unsigned SRC_VM  = 0;
  localparam int unsigned SRC_CY0 = 1;
  localparam int unsigned SRC_CY1 = 2;

  // Grant-path control state
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    PAUSED = 2'd2
  } arb_state_e;

  // Descriptor bit layout (inclusive msb/lsb)
  localparam int DSC_WADDR_MSB = 188;
  localparam int DSC_WADDR_LSB = 125;
  localparam int DSC_RADDR_MSB = 124;
  localparam int DSC_RADDR_LSB = 61;
  localparam int DSC_CIDX_MSB  = 60;
  localparam int DSC_CIDX_LSB  = 45;
  localparam int DSC_AT_MSB    = 44;
  localparam int DSC_AT_LSB    = 43;
  localparam int DSC_EOP       = 42;
  localparam int DSC_LEN_MSB   = 33;
  localparam int DSC_LEN_LSB   = 18;
  localparam int DSC_QID_MSB   = 12;
  localparam int DSC_QID_LSB   = 2;
  localparam int DSC_SDI       = 1;
  localparam int DSC_SOP       = 0;

  // Index width for an n-entry selector, never narrower than one bit
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dsc_wrr_pick.sv
// Cyclic first-eligible search starting at ptr; returns one-hot and binary winner.
// Latency: purely combinational.
// Backpressure: none; caller decides whether the pick is used.
module dsc_wrr_pick
  import qdma_dsc_arb_pkg::*;
#(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     elig,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  localparam int PW = IDX_W + 1;

  // ptr+k can reach 2N-2, so one extra bit holds the sum before the modulo fold
  logic [PW-1:0] pos;

  // Walk ptr, ptr+1, ... (mod N) and latch the first eligible slot
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    pos    = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + PW'(k);
      if (pos >= PW'(N)) pos = pos - PW'(N);
      if (!any && elig[pos[IDX_W-1:0]]) begin
        any                    = 1'b1;
        onehot[pos[IDX_W-1:0]] = 1'b1;
        idx                    = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/qdma_h2c_dsc_arbiter.sv
// Weighted round-robin arbiter with a bounded VM-agent priority lane onto the QDMA H2C bypass port.
// Latency: 1 cycle from s_dsc_vld&s_dsc_rdy to m_dsc_vld; 1 descriptor/cycle when m_dsc_rdy stays high.
// Backpressure: s_dsc_rdy only when the output register is free or draining this cycle; held beats stay stable.
module qdma_h2c_dsc_arbiter
  import qdma_dsc_arb_pkg::*;
#(
  parameter int N_REQ    = 3,
  parameter int DSC_W    = 256,
  parameter int WEIGHT_W = 4,
  parameter int HP_W     = 4,
  parameter int CNT_W    = 32,
  localparam int SRC_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [N_REQ*DSC_W-1:0]    s_dsc_data,
  input  logic [N_REQ-1:0]          s_dsc_vld,
  output logic [N_REQ-1:0]          s_dsc_rdy,
  output logic [DSC_W-1:0]          m_dsc_data,
  output logic                      m_dsc_vld,
  input  logic                      m_dsc_rdy,
  output logic [SRC_W-1:0]          m_dsc_src,
  input  logic [N_REQ*WEIGHT_W-1:0] cfg_weight,
  input  logic                      cfg_prio_en,
  input  logic [HP_W-1:0]           cfg_hp_max,
  input  logic                      cfg_pause,
  output logic                      sts_paused,
  output logic [N_REQ*CNT_W-1:0]    stat_grant_cnt,
  input  logic                      stat_clr
);

  arb_state_e          state;
  logic [SRC_W-1:0]    ptr;
  logic [WEIGHT_W-1:0] burst_cnt;
  logic [HP_W-1:0]     hp_cnt;

  logic [DSC_W-1:0]    dsc       [N_REQ];
  logic [WEIGHT_W-1:0] wgt       [N_REQ];
  logic [CNT_W-1:0]    grant_cnt [N_REQ];
  logic [N_REQ-1:0]    elig;
  logic [N_REQ-1:0]    rr_elig;
  logic [N_REQ-1:0]    rr_onehot;
  logic [SRC_W-1:0]    rr_idx;
  logic                rr_any;
  logic                others_elig;
  logic                prio_hit;
  logic [N_REQ-1:0]    grant_onehot;
  logic [SRC_W-1:0]    grant_idx;
  logic                grant_any;
  logic                load_en;
  logic                load;
  logic [N_REQ-1:0]    acc;
  logic [WEIGHT_W-1:0] win_wgt;
  logic [WEIGHT_W-1:0] burst_inc;
  logic [SRC_W-1:0]    ptr_nxt;
  logic [WEIGHT_W-1:0] burst_nxt;

  // Per-source views of the packed buses; a zero weight parks the source
  for (genvar g = 0; g < N_REQ; g++) begin : g_src
    assign dsc[g]  = s_dsc_data[g*DSC_W +: DSC_W];
    assign wgt[g]  = cfg_weight[g*WEIGHT_W +: WEIGHT_W];
    assign elig[g] = s_dsc_vld[g] & (wgt[g] != '0);
    assign stat_grant_cnt[g*CNT_W +: CNT_W] = grant_cnt[g];
  end

  assign others_elig = |elig[N_REQ-1:1];
  assign prio_hit    = cfg_prio_en & elig[SRC_VM] & (hp_cnt < cfg_hp_max);

  // While the priority lane is active, the VM agent is served by the lane and the forced
  // round-robin slot goes to a Coyote channel; it only falls back to the VM agent when
  // no channel is waiting, so a lone VM agent keeps full throughput.
  always_comb begin
    rr_elig = elig;
    if (cfg_prio_en && (cfg_hp_max != '0) && others_elig) rr_elig[SRC_VM] = 1'b0;
  end

  dsc_wrr_pick #(
    .N     (N_REQ),
    .IDX_W (SRC_W)
  ) u_pick (
    .elig   (rr_elig),
    .ptr    (ptr),
    .onehot (rr_onehot),
    .idx    (rr_idx),
    .any    (rr_any)
  );

  // Merge priority-lane and round-robin winners into one grant
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    grant_any    = 1'b0;
    if (prio_hit) begin
      grant_onehot[SRC_VM] = 1'b1;
      grant_idx            = SRC_W'(SRC_VM);
      grant_any            = 1'b1;
    end else if (rr_any) begin
      grant_onehot = rr_onehot;
      grant_idx    = rr_idx;
      grant_any    = 1'b1;
    end
  end

  assign load_en   = (state == RUN) & (~m_dsc_vld | m_dsc_rdy);
  assign load      = load_en & grant_any;
  assign s_dsc_rdy = grant_onehot & {N_REQ{load_en}};
  assign acc       = s_dsc_vld & s_dsc_rdy;

  function automatic logic [SRC_W-1:0] next_idx(input logic [SRC_W-1:0] i);
    return (i == SRC_W'(N_REQ - 1)) ? '0 : i + SRC_W'(1);
  endfunction

  // Weighted pointer update for a round-robin grant; ">=" also covers a weight lowered mid-burst
  always_comb begin
    win_wgt   = wgt[rr_idx];
    burst_inc = burst_cnt + WEIGHT_W'(1);
    ptr_nxt   = ptr;
    burst_nxt = burst_cnt;
    if (rr_idx == ptr) begin
      if (burst_inc >= win_wgt) begin
        ptr_nxt   = next_idx(rr_idx);
        burst_nxt = '0;
      end else begin
        burst_nxt = burst_inc;
      end
    end else if (win_wgt == WEIGHT_W'(1)) begin
      ptr_nxt   = next_idx(rr_idx);
      burst_nxt = '0;
    end else begin
      ptr_nxt   = rr_idx;
      burst_nxt = WEIGHT_W'(1);
    end
  end

  // Output register: load on grant, empty on handshake without grant, hold otherwise
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_dsc_vld  <= 1'b0;
      m_dsc_data <= '0;
      m_dsc_src  <= '0;
    end else if (load) begin
      m_dsc_vld  <= 1'b1;
      m_dsc_data <= dsc[grant_idx];
      m_dsc_src  <= grant_idx;
    end else if (m_dsc_rdy) begin
      m_dsc_vld  <= 1'b0;
    end
  end

  // Arbitration state: RR pointer/burst move only on RR grants; hp_cnt counts lane grants
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ptr       <= '0;
      burst_cnt <= '0;
      hp_cnt    <= '0;
    end else begin
      if (load && !prio_hit) begin
        ptr       <= ptr_nxt;
        burst_cnt <= burst_nxt;
      end
      if (!elig[SRC_VM]) begin
        hp_cnt <= '0;
      end else if (load) begin
        hp_cnt <= prio_hit ? hp_cnt + HP_W'(1) : '0;
      end
    end
  end

  // Pause/drain control; sts_paused is registered alongside the state
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= RUN;
      sts_paused <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (cfg_pause) state <= DRAIN;
        end
        DRAIN: begin
          if (!cfg_pause) begin
            state <= RUN;
          end else if (!m_dsc_vld || m_dsc_rdy) begin
            state      <= PAUSED;
            sts_paused <= 1'b1;
          end
        end
        PAUSED: begin
          if (!cfg_pause) begin
            state      <= RUN;
            sts_paused <= 1'b0;
          end
        end
        default: begin
          state      <= RUN;
          sts_paused <= 1'b0;
        end
      endcase
    end
  end

  // Accepted-descriptor counters; clear wins over a same-cycle increment
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < N_REQ; i++) grant_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (stat_clr)    grant_cnt[i] <= '0;
        else if (acc[i]) grant_cnt[i] <= grant_cnt[i] + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_qdma_h2c_dsc_arbiter.sv
// Directed bench for qdma_h2c_dsc_arbiter with an expected-beat queue.
// Sources are AXIS-like: each presents a tagged descriptor and advances on handshake.
// Expected source order comes from the documented patterns; data is derived from it.
`timescale 1ns/1ps
module tb_qdma_h2c_dsc_arbiter;
  import qdma_dsc_arb_pkg::*;

  localparam int N_REQ    = 3;
  localparam int DSC_W    = 256;
  localparam int WEIGHT_W = 4;
  localparam int HP_W     = 4;
  localparam int CNT_W    = 32;
  localparam int SRC_W    = 2;

  logic                      aclk = 1'b0;
  logic                      aresetn;
  logic [N_REQ*DSC_W-1:0]    s_dsc_data;
  logic [N_REQ-1:0]          s_dsc_vld;
  logic [N_REQ-1:0]          s_dsc_rdy;
  logic [DSC_W-1:0]          m_dsc_data;
  logic                      m_dsc_vld;
  logic                      m_dsc_rdy;
  logic [SRC_W-1:0]          m_dsc_src;
  logic [N_REQ*WEIGHT_W-1:0] cfg_weight;
  logic                      cfg_prio_en;
  logic [HP_W-1:0]           cfg_hp_max;
  logic                      cfg_pause;
  logic                      sts_paused;
  logic [N_REQ*CNT_W-1:0]    stat_grant_cnt;
  logic                      stat_clr;

  qdma_h2c_dsc_arbiter #(
    .N_REQ(N_REQ), .DSC_W(DSC_W), .WEIGHT_W(WEIGHT_W), .HP_W(HP_W), .CNT_W(CNT_W)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_dsc_data(s_dsc_data), .s_dsc_vld(s_dsc_vld), .s_dsc_rdy(s_dsc_rdy),
    .m_dsc_data(m_dsc_data), .m_dsc_vld(m_dsc_vld), .m_dsc_rdy(m_dsc_rdy),
    .m_dsc_src(m_dsc_src),
    .cfg_weight(cfg_weight), .cfg_prio_en(cfg_prio_en), .cfg_hp_max(cfg_hp_max),
    .cfg_pause(cfg_pause), .sts_paused(sts_paused),
    .stat_grant_cnt(stat_grant_cnt), .stat_clr(stat_clr)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [SRC_W-1:0] src;
    logic [DSC_W-1:0] data;
  } exp_t;

  exp_t             exp_q[$];
  int               errors = 0;
  int               checks = 0;
  int               sent  [N_REQ];
  int               exp_k [N_REQ];
  int               budget, acc_total, cyc, beats, first_beat, last_beat;
  logic [N_REQ-1:0] rdy_seen;
  logic [DSC_W-1:0] d_hold;

  int pat_w132 [6] = '{0, 1, 1, 1, 2, 2};
  int pat_hp2  [6] = '{0, 0, 1, 0, 0, 2};
  int pat_w0   [6] = '{2, 0, 2, 0, 2, 0};

  task automatic check(input string tag, input logic [DSC_W-1:0] obs, input logic [DSC_W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [DSC_W-1:0] mk_data(input int src, input int k);
    logic [DSC_W-1:0] d;
    d = '0;
    d[DSC_WADDR_MSB:DSC_WADDR_LSB] = {16'(src), 16'hBEEF, 32'(k)};
    d[DSC_RADDR_MSB:DSC_RADDR_LSB] = {32'(k) ^ 32'h5A5A_1234, 32'(src)};
    d[DSC_LEN_MSB:DSC_LEN_LSB]     = 16'(k + 1);
    d[DSC_QID_MSB:DSC_QID_LSB]     = 11'(src);
    d[DSC_SOP]                     = 1'b1;
    d[DSC_EOP]                     = 1'b1;
    d[255:240]                     = 16'hC0DE ^ 16'(k);
    return d;
  endfunction

  task automatic drive_data();
    for (int i = 0; i < N_REQ; i++) s_dsc_data[i*DSC_W +: DSC_W] = mk_data(i, sent[i]);
  endtask

  task automatic set_w(input int w2, input int w1, input int w0);
    cfg_weight = {WEIGHT_W'(w2), WEIGHT_W'(w1), WEIGHT_W'(w0)};
  endtask

  task automatic push(input int src);
    exp_t e;
    e.src  = SRC_W'(src);
    e.data = mk_data(src, exp_k[src]);
    exp_k[src]++;
    exp_q.push_back(e);
  endtask

  task automatic start_phase(input int n, input logic [N_REQ-1:0] mask);
    for (int i = 0; i < N_REQ; i++) begin
      sent[i]  = 0;
      exp_k[i] = 0;
    end
    acc_total = 0;
    budget    = n;
    beats     = 0;
    rdy_seen  = '0;
    drive_data();
    s_dsc_vld = mask;
  endtask

  // One clock: sample handshakes before the edge, then advance the sources after it
  task automatic step();
    logic [N_REQ-1:0] acc;
    exp_t e;
    #1;
    acc      = s_dsc_vld & s_dsc_rdy;
    rdy_seen = rdy_seen | s_dsc_rdy;
    if (m_dsc_vld && m_dsc_rdy) begin
      check("beat_expected", DSC_W'(exp_q.size() != 0), DSC_W'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out_src", DSC_W'(m_dsc_src), DSC_W'(e.src));
        check("out_data", m_dsc_data, e.data);
      end
      if (beats == 0) first_beat = cyc;
      last_beat = cyc;
      beats++;
    end
    @(posedge aclk);
    cyc++;
    #1;
    for (int i = 0; i < N_REQ; i++) begin
      if (acc[i]) begin
        sent[i]++;
        acc_total++;
      end
    end
    drive_data();
    if (acc != '0 && acc_total >= budget) s_dsc_vld = '0;
    #1;
  endtask

  task automatic run_until_done(input int max_cyc, input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_dsc_vld) && n < max_cyc) begin
      step();
      n++;
    end
    check(tag, DSC_W'(exp_q.size() == 0 && !m_dsc_vld), DSC_W'(1));
  endtask

  task automatic check_stats(input string tag, input int c0, input int c1, input int c2);
    check({tag, "_0"}, DSC_W'(stat_grant_cnt[0*CNT_W +: CNT_W]), DSC_W'(c0));
    check({tag, "_1"}, DSC_W'(stat_grant_cnt[1*CNT_W +: CNT_W]), DSC_W'(c1));
    check({tag, "_2"}, DSC_W'(stat_grant_cnt[2*CNT_W +: CNT_W]), DSC_W'(c2));
  endtask

  initial begin
    cyc         = 0;
    aresetn     = 1'b0;
    s_dsc_vld   = '0;
    s_dsc_data  = '0;
    m_dsc_rdy   = 1'b1;
    cfg_prio_en = 1'b0;
    cfg_hp_max  = '0;
    cfg_pause   = 1'b0;
    stat_clr    = 1'b0;
    set_w(1, 1, 1);
    repeat (2) @(posedge aclk);
    #1;
    check("rst_m_vld", DSC_W'(m_dsc_vld), DSC_W'(0));
    check("rst_m_data", m_dsc_data, DSC_W'(0));
    check("rst_m_src", DSC_W'(m_dsc_src), DSC_W'(0));
    check("rst_s_rdy", DSC_W'(s_dsc_rdy), DSC_W'(0));
    check("rst_paused", DSC_W'(sts_paused), DSC_W'(0));
    check_stats("rst_stat", 0, 0, 0);
    aresetn = 1'b1;
    #1;

    // Equal weights, round robin, full rate
    start_phase(6, 3'b111);
    for (int r = 0; r < 2; r++) begin push(0); push(1); push(2); end
    #1;
    check("p1_first_rdy", DSC_W'(s_dsc_rdy), DSC_W'(3'b001));
    check("p1_vld_before", DSC_W'(m_dsc_vld), DSC_W'(0));
    step();
    check("p1_vld_after", DSC_W'(m_dsc_vld), DSC_W'(1));
    run_until_done(20, "p1_done");
    check("p1_beats", DSC_W'(beats), DSC_W'(6));
    check("p1_back_to_back", DSC_W'(last_beat - first_beat), DSC_W'(5));

    // Weights {1,3,2} with stats
    set_w(2, 3, 1);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    check_stats("p2_clr", 0, 0, 0);
    start_phase(60, 3'b111);
    for (int i = 0; i < 60; i++) push(pat_w132[i % 6]);
    run_until_done(200, "p2_done");
    check_stats("p2_stat", 10, 30, 20);

    // Priority lane, hp_max=2 then hp_max=0
    set_w(1, 1, 1);
    cfg_prio_en = 1'b1;
    cfg_hp_max  = 4'd2;
    start_phase(12, 3'b111);
    for (int i = 0; i < 12; i++) push(pat_hp2[i % 6]);
    run_until_done(50, "p3_done");
    cfg_hp_max = 4'd0;
    start_phase(6, 3'b111);
    for (int i = 0; i < 6; i++) push(i % 3);
    run_until_done(50, "p3b_done");
    cfg_prio_en = 1'b0;

    // Output backpressure: beat held stable for 5 cycles
    m_dsc_rdy = 1'b0;
    d_hold    = mk_data(0, 0);
    start_phase(2, 3'b111);
    push(0); push(1);
    step();
    for (int c = 0; c < 5; c++) begin
      step();
      check("p4_hold_data", m_dsc_data, d_hold);
      check("p4_hold_vld", DSC_W'(m_dsc_vld), DSC_W'(1));
      check("p4_hold_rdy", DSC_W'(s_dsc_rdy), DSC_W'(0));
    end
    m_dsc_rdy = 1'b1;
    step();
    step();
    check("p4_two_beats", DSC_W'(exp_q.size()), DSC_W'(0));
    check("p4_vld_falls", DSC_W'(m_dsc_vld), DSC_W'(0));

    // Pause while a beat is stuck, then drain, pause, resume
    m_dsc_rdy = 1'b0;
    start_phase(2, 3'b111);
    push(2); push(0);
    step();
    cfg_pause = 1'b1;
    step();
    check("p5_drain_rdy", DSC_W'(s_dsc_rdy), DSC_W'(0));
    check("p5_drain_sts", DSC_W'(sts_paused), DSC_W'(0));
    step();
    check("p5_drain_hold", DSC_W'(m_dsc_vld), DSC_W'(1));
    m_dsc_rdy = 1'b1;
    #1;
    check("p5_drain_rdy_out", DSC_W'(s_dsc_rdy), DSC_W'(0));
    step();
    check("p5_paused", DSC_W'(sts_paused), DSC_W'(1));
    check("p5_paused_empty", DSC_W'(m_dsc_vld), DSC_W'(0));
    step();
    check("p5_paused_rdy", DSC_W'(s_dsc_rdy), DSC_W'(0));
    check("p5_paused_hold", DSC_W'(sts_paused), DSC_W'(1));
    cfg_pause = 1'b0;
    step();
    check("p5_resume_sts", DSC_W'(sts_paused), DSC_W'(0));
    check("p5_resume_ptr", DSC_W'(s_dsc_rdy), DSC_W'(3'b001));
    run_until_done(20, "p5_done");

    // Zero weight parks source 1
    set_w(1, 0, 1);
    start_phase(6, 3'b111);
    for (int i = 0; i < 6; i++) push(pat_w0[i]);
    run_until_done(30, "p6_done");
    check("p6_src1_never_rdy", DSC_W'(rdy_seen[1]), DSC_W'(0));

    // Reset mid-stream
    set_w(1, 1, 1);
    start_phase(100, 3'b111);
    push(1); push(2); push(0);
    step(); step(); step();
    check("p7_pre_rst_vld", DSC_W'(m_dsc_vld), DSC_W'(1));
    aresetn = 1'b0;
    #1;
    check("p7_rst_async_vld", DSC_W'(m_dsc_vld), DSC_W'(0));
    check_stats("p7_rst_stat", 0, 0, 0);
    s_dsc_vld = '0;
    exp_q.delete();
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    #1;
    start_phase(3, 3'b111);
    push(0); push(1); push(2);
    #1;
    check("p7_first_after_rst", DSC_W'(s_dsc_rdy), DSC_W'(3'b001));
    run_until_done(20, "p7_done");
    check_stats("p7_stat", 1, 1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
